// File: rtl/dlatch_pkg.sv
// Shared definitions for the dlatch FIFO slice: width helpers and the reset polarity.
package dlatch_pkg;

    localparam logic RST_ACTIVE = 1'b0;

    function automatic int W(input int s);
        return 2 ** s;
    endfunction

    function automatic int PW(input int d);
        return d + 1;
    endfunction

endpackage

// File: rtl/dlatch_fifo_mem.sv
// DEPTH x W storage array for dlatch_fifo: one write port, asynchronous read, synchronous clear.
module dlatch_fifo_mem
    import dlatch_pkg::*;
#(
    parameter int S = 3,
    parameter int D = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [D-1:0]    waddr,
    input  logic [W(S)-1:0] wdata,
    input  logic [D-1:0]    raddr,
    output logic [W(S)-1:0] rdata
);

    localparam int DEPTH = 2 ** D;

    logic [W(S)-1:0] mem [DEPTH];

    // Clearing on reset keeps stale words from a previous run out of the array.
    always_ff @(posedge clk) begin
        if (reset == RST_ACTIVE) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dlatch_fifo.sv
// Valid/ready FIFO feeding a multi_Dlatch bank; out/out_n mirror the bank's Q/Qbar.
// Optional occupancy port `count` is present only when DLATCH_FIFO_COUNT_EN is defined.
module dlatch_fifo
    import dlatch_pkg::*;
#(
    parameter int S = 3,
    parameter int D = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [W(S)-1:0] in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [W(S)-1:0] out,
    output logic [W(S)-1:0] out_n,
    output logic            out_valid,
    input  logic            out_ready
`ifdef DLATCH_FIFO_COUNT_EN
    ,
    output logic [PW(D)-1:0] count
`endif
);

    localparam int                PTR_W   = PW(D);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [W(S)-1:0]  rdata;

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[D] != rd_ptr[D]) && (wr_ptr[D-1:0] == rd_ptr[D-1:0]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset == RST_ACTIVE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    dlatch_fifo_mem #(
        .S(S),
        .D(D)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr[D-1:0]),
        .wdata (in),
        .raddr (rd_ptr[D-1:0]),
        .rdata (rdata)
    );

    // Head word is masked to zero when empty so the latch bank sees a clean idle value.
    assign out   = out_valid ? rdata : '0;
    assign out_n = ~out;

`ifdef DLATCH_FIFO_COUNT_EN
    assign count = wr_ptr - rd_ptr;
`endif

endmodule
